// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Two-port arbiter in front of a single memory port. The memory writes
// synchronously and reads combinationally. The CPU has fixed priority, and
// an anti-starvation counter forces one DMA win after STARVE_LIMIT
// consecutive lost arbitrations. Only one access is outstanding at a time.
// Each access holds the bus for WAIT_CYCLES+1 cycles.
//
// Optional feature (macro MEMARB_LOCK_EN): adds the cpu_lock input. The CPU
// can then keep the bus across a read-modify-write sequence.
//
// Ports:
//   clk, reset                 clock (rising edge), async active-low reset
//   cpu_req/we/addr/wdata      CPU request side
//   cpu_rdata, cpu_ack         CPU read data and one-cycle completion pulse
//   dma_req/we/addr/wdata      DMA request side
//   dma_rdata, dma_ack         DMA read data and one-cycle completion pulse
//   mem_en/we/addr/wdata       memory port drive
//   mem_rdata                  combinational memory read data
//   owner                      0 = CPU, 1 = DMA (last/current grant)
//   busy                       high while in ACCESS
//   cpu_lock                   (MEMARB_LOCK_EN only) hold bus for the CPU
//   state_dbg                  FSM state (0 = IDLE, 1 = ACCESS)
//   starve_cnt                 current DMA starvation count
//
// Handshake: a requester raises req with stable we/addr/wdata and keeps them
// stable until its ack. Ack is a single-cycle pulse, and rdata is valid in
// that cycle. If req is still high in the ack cycle, a new request starts.
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 8,
  parameter int WAIT_CYCLES  = 1,
  parameter int STARVE_LIMIT = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
`ifdef MEMARB_LOCK_EN
  input  logic          cpu_lock,
`endif
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner,
  output logic          busy,
  output logic          state_dbg,
  output logic [3:0]    starve_cnt
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dma_rdata_q, dma_rdata_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          dma_ack_q, dma_ack_d;
  logic [3:0]    starve_q, starve_d;
  logic [3:0]    wait_q, wait_d;
  logic          lock_active;
  logic          start;
  logic          pick_dma;

`ifdef MEMARB_LOCK_EN
  logic lock_q, lock_d;
  // The lock only holds while cpu_lock is still high. The first IDLE cycle
  // with cpu_lock low releases it.
  assign lock_active = lock_q & cpu_lock;
`else
  assign lock_active = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      starve_q    <= '0;
      wait_q      <= '0;
`ifdef MEMARB_LOCK_EN
      lock_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
      starve_q    <= starve_d;
      wait_q      <= wait_d;
`ifdef MEMARB_LOCK_EN
      lock_q      <= lock_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    cpu_ack_d   = 1'b0;
    dma_ack_d   = 1'b0;
    starve_d    = starve_q;
    wait_d      = wait_q;
    start       = 1'b0;
    pick_dma    = 1'b0;
`ifdef MEMARB_LOCK_EN
    lock_d      = lock_q;
`endif

    case (state_q)
      ST_IDLE: begin
`ifdef MEMARB_LOCK_EN
        if (!cpu_lock) lock_d = 1'b0;
`endif
        if (lock_active) begin
          // While locked, only the CPU can win, and DMA's loss is not
          // counted as starvation.
          start = cpu_req;
        end else if (cpu_req && dma_req) begin
          start = 1'b1;
          if (starve_q >= 4'(STARVE_LIMIT)) begin
            pick_dma = 1'b1;
            starve_d = '0;
          end else if (starve_q != 4'hF) begin
            starve_d = starve_q + 4'd1;
          end
        end else if (cpu_req) begin
          start = 1'b1;
        end else if (dma_req) begin
          start    = 1'b1;
          pick_dma = 1'b1;
          starve_d = '0;
        end

        if (start) begin
          state_d = ST_ACCESS;
          owner_d = pick_dma;
          wait_d  = 4'(WAIT_CYCLES);
          we_d    = pick_dma ? dma_we    : cpu_we;
          addr_d  = pick_dma ? dma_addr  : cpu_addr;
          wdata_d = pick_dma ? dma_wdata : cpu_wdata;
        end
      end

      ST_ACCESS: begin
        if (wait_q != '0) begin
          wait_d = wait_q - 4'd1;
        end else begin
          // Last access cycle. Capture read data for the owner (also on
          // writes) and pulse its ack.
          state_d = ST_IDLE;
          if (owner_q) begin
            dma_rdata_d = mem_rdata;
            dma_ack_d   = 1'b1;
          end else begin
            cpu_rdata_d = mem_rdata;
            cpu_ack_d   = 1'b1;
`ifdef MEMARB_LOCK_EN
            lock_d      = cpu_lock;
`endif
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_en     = (state_q == ST_ACCESS);
  assign busy       = (state_q == ST_ACCESS);
  assign mem_we     = (state_q == ST_ACCESS) & we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dma_rdata  = dma_rdata_q;
  assign cpu_ack    = cpu_ack_q;
  assign dma_ack    = dma_ack_q;
  assign owner      = owner_q;
  assign state_dbg  = state_q;
  assign starve_cnt = starve_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter. The main instance uses WAIT_CYCLES=1 and
// STARVE_LIMIT=3. A second instance uses WAIT_CYCLES=0 and covers
// back-to-back CPU reads. Each instance has its own simple memory model.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0] cpu_addr, dma_addr, mem_addr;
  logic [7:0]  cpu_wdata, dma_wdata, cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
  logic        cpu_ack, dma_ack, mem_en, mem_we, owner, busy, state_dbg;
  logic [3:0]  starve_cnt;
  logic [7:0]  mem [0:65535];

  logic        z_cpu_req, z_cpu_we, z_dma_req, z_dma_we;
  logic [15:0] z_cpu_addr, z_dma_addr, z_mem_addr;
  logic [7:0]  z_cpu_wdata, z_dma_wdata, z_cpu_rdata, z_dma_rdata;
  logic [7:0]  z_mem_wdata, z_mem_rdata;
  logic        z_cpu_ack, z_dma_ack, z_mem_en, z_mem_we, z_owner, z_busy, z_state_dbg;
  logic [3:0]  z_starve_cnt;
  logic [7:0]  z_mem [0:65535];

`ifdef MEMARB_LOCK_EN
  logic        cpu_lock;
  logic        z_cpu_lock;
`endif

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  // Clock.
  always #5 clk = ~clk;

  mem_arbiter #(.AW(16), .DW(8), .WAIT_CYCLES(1), .STARVE_LIMIT(3)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
`ifdef MEMARB_LOCK_EN
    .cpu_lock(cpu_lock),
`endif
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner), .busy(busy),
    .state_dbg(state_dbg), .starve_cnt(starve_cnt)
  );

  mem_arbiter #(.AW(16), .DW(8), .WAIT_CYCLES(0), .STARVE_LIMIT(3)) u_dut0 (
    .clk(clk), .reset(reset),
    .cpu_req(z_cpu_req), .cpu_we(z_cpu_we), .cpu_addr(z_cpu_addr), .cpu_wdata(z_cpu_wdata),
    .cpu_rdata(z_cpu_rdata), .cpu_ack(z_cpu_ack),
    .dma_req(z_dma_req), .dma_we(z_dma_we), .dma_addr(z_dma_addr), .dma_wdata(z_dma_wdata),
    .dma_rdata(z_dma_rdata), .dma_ack(z_dma_ack),
`ifdef MEMARB_LOCK_EN
    .cpu_lock(z_cpu_lock),
`endif
    .mem_en(z_mem_en), .mem_we(z_mem_we), .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata),
    .mem_rdata(z_mem_rdata), .owner(z_owner), .busy(z_busy),
    .state_dbg(z_state_dbg), .starve_cnt(z_starve_cnt)
  );

  // Memory models: combinational read, write at the rising edge.
  assign mem_rdata   = mem[mem_addr];
  assign z_mem_rdata = z_mem[z_mem_addr];
  always @(posedge clk) if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
  always @(posedge clk) if (z_mem_en && z_mem_we) z_mem[z_mem_addr] <= z_mem_wdata;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Issue one CPU transfer from a negedge and wait (bounded) for its ack.
  task automatic cpu_xfer(input logic we, input logic [15:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output logic ok);
    cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
    ok = 1'b0; rd = '0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (cpu_ack) begin ok = 1'b1; rd = cpu_rdata; end
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    logic       ok;
    logic       flag;
    int         got;

    reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    z_cpu_req = 0; z_cpu_we = 0; z_cpu_addr = 0; z_cpu_wdata = 0;
    z_dma_req = 0; z_dma_we = 0; z_dma_addr = 0; z_dma_wdata = 0;
`ifdef MEMARB_LOCK_EN
    cpu_lock = 0; z_cpu_lock = 0;
`endif
    for (int i = 0; i < 65536; i++) begin mem[i] = 8'h00; z_mem[i] = 8'h00; end
    mem[16'h1234] = 8'h5A;
    mem[16'h0040] = 8'h11;
    z_mem[16'h0000] = 8'hA1;
    z_mem[16'h0001] = 8'hB2;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_acks", 32'({cpu_ack, dma_ack}), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_rdata", 32'({cpu_rdata, dma_rdata}), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_starve", 32'(starve_cnt), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // ---- single CPU read, ack 3 cycles after req ----
    cpu_we = 0; cpu_addr = 16'h1234; cpu_req = 1;
    @(negedge clk);
    check("t1_en_c1", 32'(mem_en), 32'd1);
    check("t1_addr", 32'(mem_addr), 32'h1234);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_ack_c1", 32'(cpu_ack), 32'd0);
    @(negedge clk);
    check("t1_en_c2", 32'(mem_en), 32'd1);
    check("t1_ack_c2", 32'(cpu_ack), 32'd0);
    @(negedge clk);
    check("t1_ack", 32'(cpu_ack), 32'd1);
    check("t1_rdata", 32'(cpu_rdata), 32'h5A);
    check("t1_en_off", 32'(mem_en), 32'd0);
    check("t1_dma_ack", 32'(dma_ack), 32'd0);
    cpu_req = 0;
    @(negedge clk);
    check("t1_ack_pulse", 32'(cpu_ack), 32'd0);
    check("t1_idle", 32'(mem_en), 32'd0);

    // ---- DMA write 8000 <= C3 ----
    dma_we = 1; dma_addr = 16'h8000; dma_wdata = 8'hC3; dma_req = 1;
    @(negedge clk);
    check("t2_we_c1", 32'({mem_en, mem_we}), 32'h3);
    check("t2_owner", 32'(owner), 32'd1);
    check("t2_addr", 32'(mem_addr), 32'h8000);
    check("t2_wdata", 32'(mem_wdata), 32'hC3);
    @(negedge clk);
    check("t2_we_c2", 32'({mem_en, mem_we}), 32'h3);
    check("t2_ack_early", 32'(dma_ack), 32'd0);
    @(negedge clk);
    check("t2_ack", 32'({cpu_ack, dma_ack}), 32'h1);
    check("t2_rdata", 32'(dma_rdata), 32'hC3);
    check("t2_cpu_rdata_kept", 32'(cpu_rdata), 32'h5A);
    check("t2_we_off", 32'(mem_we), 32'd0);
    check("t2_mem", 32'(mem[16'h8000]), 32'hC3);
    dma_req = 0; dma_we = 0;
    @(negedge clk);
    check("t2_ack_pulse", 32'(dma_ack), 32'd0);

    // ---- both requesting continuously: 3 CPU wins then 1 DMA win ----
    exp_q = {8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    got_q.delete();
    cpu_we = 0; cpu_addr = 16'h0010; dma_we = 0; dma_addr = 16'h0020;
    cpu_req = 1; dma_req = 1;
    flag = 0;
    for (int cyc = 0; cyc < 100 && got_q.size() < 8; cyc++) begin
      @(negedge clk);
      if (cpu_ack && dma_ack) flag = 1;
      if (cpu_ack) got_q.push_back(8'd0);
      if (dma_ack) got_q.push_back(8'd1);
    end
    cpu_req = 0; dma_req = 0;
    got = got_q.size();
    check("t3_grants", 32'(got), 32'd8);
    check("t3_two_acks", 32'(flag), 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (i < got) check($sformatf("t3_grant%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
      else check($sformatf("t3_grant%0d", i), 32'hFF, 32'(exp_q[i]));
    end
    @(negedge clk);
    check("t3_starve_end", 32'(starve_cnt), 32'd0);

    // ---- reset asserted in the first ACCESS cycle of a CPU write ----
    cpu_we = 1; cpu_addr = 16'h0040; cpu_wdata = 8'h77; cpu_req = 1;
    @(posedge clk);
    #2;
    check("t4_pre_en", 32'({mem_en, mem_we}), 32'h3);
    reset = 1'b0; cpu_req = 0; cpu_we = 0;
    #1;
    check("t4_async_drop", 32'({mem_en, mem_we, busy}), 32'd0);
    flag = 0;
    repeat (4) begin
      @(negedge clk);
      if (cpu_ack) flag = 1;
    end
    check("t4_no_ack", 32'(flag), 32'd0);
    check("t4_mem_kept", 32'(mem[16'h0040]), 32'h11);
    reset = 1'b1;
    @(negedge clk);
    cpu_xfer(1'b0, 16'h0040, 8'h00, rd, ok);
    check("t4_fresh_ok", 32'(ok), 32'd1);
    check("t4_fresh_rd", 32'(rd), 32'h11);
    cpu_xfer(1'b1, 16'h0040, 8'h66, rd, ok);
    check("t4_write_ok", 32'(ok), 32'd1);
    check("t4_write_mem", 32'(mem[16'h0040]), 32'h66);

    // ---- WAIT_CYCLES=0 back-to-back CPU reads ----
    z_cpu_we = 0; z_cpu_addr = 16'h0000; z_cpu_req = 1;
    @(negedge clk);
    check("t5_en_a", 32'(z_mem_en), 32'd1);
    check("t5_addr_a", 32'(z_mem_addr), 32'h0000);
    @(negedge clk);
    check("t5_ack_a", 32'(z_cpu_ack), 32'd1);
    check("t5_rd_a", 32'(z_cpu_rdata), 32'hA1);
    z_cpu_addr = 16'h0001;
    @(negedge clk);
    check("t5_en_b", 32'(z_mem_en), 32'd1);
    check("t5_addr_b", 32'(z_mem_addr), 32'h0001);
    check("t5_gap", 32'(z_cpu_ack), 32'd0);
    @(negedge clk);
    check("t5_ack_b", 32'(z_cpu_ack), 32'd1);
    check("t5_rd_b", 32'(z_cpu_rdata), 32'hB2);
    z_cpu_req = 0;
    @(negedge clk);
    check("t5_ack_pulse", 32'(z_cpu_ack), 32'd0);

`ifdef MEMARB_LOCK_EN
    // ---- locked read-modify-write with DMA waiting ----
    cpu_lock = 1; cpu_we = 0; cpu_addr = 16'h1234;
    dma_we = 0; dma_addr = 16'h0020;
    cpu_req = 1; dma_req = 1;
    ok = 0; flag = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (dma_ack) flag = 1;
      if (cpu_ack) ok = 1;
    end
    check("t6_rd_ok", 32'(ok), 32'd1);
    check("t6_rd_data", 32'(cpu_rdata), 32'h5A);
    check("t6_starve_a", 32'(starve_cnt), 32'd1);
    cpu_we = 1; cpu_addr = 16'h0050; cpu_wdata = 8'h9C;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (dma_ack) flag = 1;
      if (cpu_ack) ok = 1;
    end
    check("t6_wr_ok", 32'(ok), 32'd1);
    check("t6_no_dma", 32'(flag), 32'd0);
    check("t6_starve_b", 32'(starve_cnt), 32'd1);
    cpu_req = 0; cpu_we = 0;
    @(negedge clk);
    check("t6_dma_waits", 32'(mem_en), 32'd0);
    check("t6_mem", 32'(mem[16'h0050]), 32'h9C);
    cpu_lock = 0;
    @(negedge clk);
    check("t6_dma_grant", 32'({mem_en, owner}), 32'h3);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (dma_ack) ok = 1;
    end
    check("t6_dma_ok", 32'(ok), 32'd1);
    check("t6_starve_c", 32'(starve_cnt), 32'd0);
    dma_req = 0;
    @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
